reg_display_scheduler: RTL and testbench

REG_DISPLAY_SCHEDULER -- requirements
Module: reg_display_scheduler

---
 rtl/reg_display_scheduler_if.sv | 19 +
 rtl/reg_display_scheduler.sv | 97 +++++++++
 tb/tb_reg_display_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_display_scheduler_if.sv
// reg_display_scheduler_if: keyboard input, MARIE register values and display outputs of the scheduler
interface reg_display_scheduler_if;
    logic [7:0]  key_code;
    logic        key_valid;
    logic [15:0] mar, mbr, ir, pc, inreg, outreg, ac;
    logic [15:0] disp_data;
    logic [2:0]  disp_sel;
    logic [1:0]  mode;

    modport master (
        output key_code, key_valid, mar, mbr, ir, pc, inreg, outreg, ac,
        input  disp_data, disp_sel, mode
    );

    modport slave (
        input  key_code, key_valid, mar, mbr, ir, pc, inreg, outreg, ac,
        output disp_data, disp_sel, mode
    );
endinterface

// File: rtl/reg_display_scheduler.sv
// reg_display_scheduler: PS/2-key driven selection, auto-scan and freeze of MARIE register display
module reg_display_scheduler #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    reg_display_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, MANUAL = 2'b01, SCAN = 2'b10, FROZEN = 2'b11} state_t;
    localparam logic [31:0] LAST = 32'(DWELL - 1);

    state_t      state, state_n;
    logic [2:0]  sel, sel_n, reg_id;
    logic [31:0] cnt, cnt_n;
    logic [15:0] data, data_n, snap, snap_n, src;
    logic        brk, brk_n, from_scan, from_scan_n, act, k_r, k_d, k_f;

    assign src = sel == 3'd1 ? bus.mar :
                 sel == 3'd2 ? bus.mbr :
                 sel == 3'd3 ? bus.ir :
                 sel == 3'd4 ? bus.pc :
                 sel == 3'd5 ? bus.inreg :
                 sel == 3'd6 ? bus.outreg :
                 sel == 3'd7 ? bus.ac : 16'h0000;

    // A byte following F0 is a key release: it only clears the break flag
    always_comb begin
        act = bus.key_valid && bus.key_code != 8'hE0 && bus.key_code != 8'hF0 && !brk;
        brk_n = (bus.key_valid && bus.key_code != 8'hE0) ? (!brk && bus.key_code == 8'hF0) : brk;
        reg_id = !act                 ? 3'd0 :
                 bus.key_code == 8'h3A ? 3'd1 :
                 bus.key_code == 8'h32 ? 3'd2 :
                 bus.key_code == 8'h43 ? 3'd3 :
                 bus.key_code == 8'h4D ? 3'd4 :
                 bus.key_code == 8'h31 ? 3'd5 :
                 bus.key_code == 8'h44 ? 3'd6 :
                 bus.key_code == 8'h1C ? 3'd7 : 3'd0;
        k_r = act && bus.key_code == 8'h2D;
        k_d = act && bus.key_code == 8'h23;
        k_f = act && bus.key_code == 8'h2B;
    end

    always_comb begin
        state_n = state;
        sel_n = sel;
        cnt_n = cnt;
        from_scan_n = from_scan;
        if (k_r) begin
            state_n = IDLE;
            sel_n = 3'd0;
            cnt_n = 32'd0;
        end else if (state == FROZEN) begin
            if (k_f) state_n = from_scan ? SCAN : MANUAL;
        end else if (reg_id != 3'd0) begin
            state_n = MANUAL;
            sel_n = reg_id;
            cnt_n = 32'd0;
        end else if (k_d) begin
            state_n = state == SCAN ? MANUAL : SCAN;
            sel_n = state == SCAN ? sel : 3'd1;
            cnt_n = 32'd0;
        end else if (k_f && state != IDLE) begin
            state_n = FROZEN;
            from_scan_n = state == SCAN;
        end else if (state == SCAN) begin
            cnt_n = cnt == LAST ? 32'd0 : cnt + 32'd1;
            sel_n = cnt != LAST ? sel : sel == 3'd7 ? 3'd1 : sel + 3'd1;
        end
        // The snapshot is the value already on the display when the freeze key lands
        snap_n = k_r ? 16'h0000 : (state != FROZEN && state_n == FROZEN) ? data : snap;
        data_n = k_r ? 16'h0000 : state_n == FROZEN ? snap_n : src;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= 3'd0;
            cnt <= 32'd0;
            data <= 16'h0000;
            snap <= 16'h0000;
            brk <= 1'b0;
            from_scan <= 1'b0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            cnt <= cnt_n;
            data <= data_n;
            snap <= snap_n;
            brk <= brk_n;
            from_scan <= from_scan_n;
        end
    end

    assign bus.mode = state;
    assign bus.disp_sel = sel;
    assign bus.disp_data = data;
endmodule

// File: tb/tb_reg_display_scheduler.sv
// tb_reg_display_scheduler: directed and random key/register stimulus against a behavioural display model
module tb_reg_display_scheduler;
    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    reg_display_scheduler_if bus();

    reg_display_scheduler #(.DWELL(DWELL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_mode, m_sel, left;
    logic [15:0] m_data, m_snap;
    bit          m_brk, m_from, started;

    logic [7:0] rk [7] = '{8'h3A, 8'h32, 8'h43, 8'h4D, 8'h31, 8'h44, 8'h1C};
    logic [7:0] kc [14] = '{8'h3A, 8'h32, 8'h43, 8'h4D, 8'h31, 8'h44, 8'h1C,
                            8'h23, 8'h2B, 8'h2D, 8'hF0, 8'hE0, 8'h55, 8'h00};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int reg_of(input logic [7:0] c);
        for (int i = 0; i < 7; i++)
            if (rk[i] == c) return i + 1;
        return 0;
    endfunction

    // Model: mode/sel/display with a dwell countdown of cycles left on the current register
    always @(posedge clk) begin
        int nm, ns, r;
        bit act;
        logic [15:0] nd;
        logic [15:0] v [8];
        started = 1;
        if (!rst_n) begin
            m_mode = 0; m_sel = 0; m_data = 0; m_snap = 0; left = DWELL; m_brk = 0; m_from = 0;
        end else begin
            v[0] = 0; v[1] = bus.mar; v[2] = bus.mbr; v[3] = bus.ir;
            v[4] = bus.pc; v[5] = bus.inreg; v[6] = bus.outreg; v[7] = bus.ac;
            act = 0;
            if (bus.key_valid && bus.key_code != 8'hE0) begin
                if (m_brk) m_brk = 0;
                else if (bus.key_code == 8'hF0) m_brk = 1;
                else act = 1;
            end
            r = act ? reg_of(bus.key_code) : 0;
            nm = m_mode;
            ns = m_sel;
            nd = v[m_sel];
            if (act && bus.key_code == 8'h2D) begin
                nm = 0; ns = 0; m_snap = 0; nd = 0;
            end else if (m_mode == 3) begin
                if (act && bus.key_code == 8'h2B) nm = m_from ? 2 : 1;
            end else if (r != 0) begin
                nm = 1; ns = r;
            end else if (act && bus.key_code == 8'h23) begin
                if (m_mode == 2) nm = 1;
                else begin nm = 2; ns = 1; left = DWELL; end
            end else if (act && bus.key_code == 8'h2B && m_mode != 0) begin
                m_from = (m_mode == 2); nm = 3; m_snap = m_data;
            end else if (m_mode == 2) begin
                if (left == 1) begin ns = ns % 7 + 1; left = DWELL; end
                else left--;
            end
            if (nm == 3) nd = m_snap;
            m_mode = nm; m_sel = ns; m_data = nd;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("mode", 32'(bus.mode), 32'(m_mode));
            check("disp_sel", 32'(bus.disp_sel), 32'(m_sel));
            check("disp_data", 32'(bus.disp_data), 32'(m_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] c);
        bus.key_valid = 1'b1;
        bus.key_code = c;
        step();
        bus.key_valid = 1'b0;
    endtask

    initial begin
        bus.key_valid = 0; bus.key_code = 0;
        bus.mar = 16'h1111; bus.mbr = 16'h2222; bus.ir = 16'h3333; bus.pc = 16'h0123;
        bus.inreg = 16'h5555; bus.outreg = 16'h6666; bus.ac = 16'h7777;
        step(); step();
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_sel", 32'(bus.disp_sel), 0);
        check("rst_data", 32'(bus.disp_data), 0);
        rst_n = 1;
        step();
        press(8'h4D);
        check("pc_mode", 32'(bus.mode), 1);
        check("pc_sel", 32'(bus.disp_sel), 4);
        check("model_pc_sel", 32'(m_sel), 4);
        step();
        check("pc_data", 32'(bus.disp_data), 32'h0123);
        bus.pc = 16'h0124;
        step();
        check("pc_track", 32'(bus.disp_data), 32'h0124);
        press(8'h4D); check("brk_a", 32'(bus.disp_sel), 4);
        press(8'hF0); check("brk_b", 32'(bus.disp_sel), 4);
        press(8'h4D); check("brk_rel", 32'(bus.disp_sel), 4);
        press(8'h3A); check("brk_m", 32'(bus.disp_sel), 1);
        press(8'hE0); press(8'hF0); press(8'hE0); press(8'h3A);
        check("e0_keep", 32'(bus.disp_sel), 1);
        press(8'h32); check("after_rel", 32'(bus.disp_sel), 2);
        press(8'h2D); check("r_idle", 32'(bus.mode), 0);
        press(8'h23);
        check("scan_mode", 32'(bus.mode), 2);
        for (int i = 0; i < 32; i++) begin
            check("scan_seq", 32'(bus.disp_sel), 32'((i / 4) % 7 + 1));
            step();
        end
        press(8'h23);
        check("scan_exit_mode", 32'(bus.mode), 1);
        check("scan_exit_sel", 32'(bus.disp_sel), 2);
        bus.ac = 16'hBEEF; bus.ir = 16'h1234;
        press(8'h23);
        repeat (9) step();
        check("pre_frz_sel", 32'(bus.disp_sel), 3);
        press(8'h2B);
        check("frz_mode", 32'(bus.mode), 3);
        check("frz_data", 32'(bus.disp_data), 32'h1234);
        bus.ir = 16'h5555;
        repeat (3) step();
        check("frz_hold", 32'(bus.disp_data), 32'h1234);
        press(8'h32);
        check("frz_ign_mode", 32'(bus.mode), 3);
        check("frz_ign_sel", 32'(bus.disp_sel), 3);
        press(8'h2B);
        check("unfrz_mode", 32'(bus.mode), 2);
        check("unfrz_data", 32'(bus.disp_data), 32'h5555);
        step(); check("resume_a", 32'(bus.disp_sel), 3);
        step(); check("resume_b", 32'(bus.disp_sel), 3);
        step(); check("resume_c", 32'(bus.disp_sel), 4);
        press(8'h2B);
        press(8'h2D);
        check("rfrz_mode", 32'(bus.mode), 0);
        check("rfrz_sel", 32'(bus.disp_sel), 0);
        check("rfrz_data", 32'(bus.disp_data), 0);
        press(8'h23);
        step(); step();
        rst_n = 0;
        bus.key_valid = 1; bus.key_code = 8'h4D;
        step();
        bus.key_valid = 0;
        check("rscan_mode", 32'(bus.mode), 0);
        check("rscan_sel", 32'(bus.disp_sel), 0);
        check("rscan_data", 32'(bus.disp_data), 0);
        rst_n = 1;
        step();
        press(8'h23);
        repeat (27) step();
        check("pre_tie_sel", 32'(bus.disp_sel), 7);
        press(8'h43);
        check("tie_mode", 32'(bus.mode), 1);
        check("tie_sel", 32'(bus.disp_sel), 3);
        check("model_tie_sel", 32'(m_sel), 3);
        for (int i = 0; i < 3000; i++) begin
            bus.key_valid = ($urandom_range(3) == 0);
            bus.key_code = kc[$urandom_range(13)];
            if ($urandom_range(4) == 0)
                case ($urandom_range(6))
                    0: bus.mar = 16'($urandom);
                    1: bus.mbr = 16'($urandom);
                    2: bus.ir = 16'($urandom);
                    3: bus.pc = 16'($urandom);
                    4: bus.inreg = 16'($urandom);
                    5: bus.outreg = 16'($urandom);
                    default: bus.ac = 16'($urandom);
                endcase
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        bus.key_valid = 0;
        rst_n = 1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
